// File: rtl/seg7_decoder.sv
// seg7_decoder: debounces an active-low 7-segment bus and emits one
// decoded record per distinct stable glyph through a valid/ready port.
// Short glitches and repeats of the last accepted glyph produce no record.
module seg7_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic       out_ready,
    input  logic       ovr_clr,
    output logic       out_valid,
    output logic [3:0] out_value,
    output logic       out_dp,
    output logic       out_blank,
    output logic       out_err,
    output logic       ovr
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // Glyph lookup: returns {blank, err, value[3:0]} for an active-low a..g pattern.
    function automatic logic [5:0] decode_f(input logic [6:0] segs);
        logic [5:0] res;
        case (segs)
            7'h40:   res = {1'b0, 1'b0, 4'h0};
            7'h79:   res = {1'b0, 1'b0, 4'h1};
            7'h24:   res = {1'b0, 1'b0, 4'h2};
            7'h30:   res = {1'b0, 1'b0, 4'h3};
            7'h19:   res = {1'b0, 1'b0, 4'h4};
            7'h12:   res = {1'b0, 1'b0, 4'h5};
            7'h02:   res = {1'b0, 1'b0, 4'h6};
            7'h78:   res = {1'b0, 1'b0, 4'h7};
            7'h00:   res = {1'b0, 1'b0, 4'h8};
            7'h10:   res = {1'b0, 1'b0, 4'h9};
            7'h08:   res = {1'b0, 1'b0, 4'hA};
            7'h03:   res = {1'b0, 1'b0, 4'hB};
            7'h46:   res = {1'b0, 1'b0, 4'hC};
            7'h21:   res = {1'b0, 1'b0, 4'hD};
            7'h06:   res = {1'b0, 1'b0, 4'hE};
            7'h0E:   res = {1'b0, 1'b0, 4'hF};
            7'h7F:   res = {1'b1, 1'b0, 4'h0};
            default: res = {1'b0, 1'b1, 4'h0};
        endcase
        return res;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] seg_q_r;
    logic [7:0] cand_r;
    logic [7:0] cand_next_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic [7:0] last_acc_r;
    logic [7:0] last_acc_next_s;
    logic       first_flag_r;
    logic       first_next_s;
    logic       emit_s;
    logic [5:0] rec_s;

    // Next-state, debounce counter and emit decision, all driven from the registered bus.
    always_comb begin
        state_next_s    = state_r;
        cand_next_s     = cand_r;
        cnt_next_s      = cnt_r;
        last_acc_next_s = last_acc_r;
        first_next_s    = first_flag_r;
        emit_s          = 1'b0;
        case (state_r)
            SETTLE: begin
                if (seg_q_r != cand_r) begin
                    cand_next_s = seg_q_r;
                    cnt_next_s  = 8'd1;
                end else if (cnt_r >= STABLE_C) begin
                    cnt_next_s = STABLE_C;
                end else begin
                    cnt_next_s = cnt_r + 8'd1;
                end
                if (cnt_next_s == STABLE_C) begin
                    state_next_s    = HOLD;
                    last_acc_next_s = cand_next_s;
                    first_next_s    = 1'b0;
                    // A stable repeat of the last accepted glyph is a rejected glitch.
                    if ((cand_next_s != last_acc_r) || first_flag_r) begin
                        emit_s = 1'b1;
                    end else begin
                        emit_s = 1'b0;
                    end
                end else begin
                    state_next_s = SETTLE;
                end
            end
            HOLD: begin
                if (seg_q_r != last_acc_r) begin
                    state_next_s = SETTLE;
                    cand_next_s  = seg_q_r;
                    cnt_next_s   = 8'd1;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = SETTLE;
            end
        endcase
    end

    assign rec_s = decode_f(cand_next_s[6:0]);

    // Input sampling register and debounce/FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= SETTLE;
            seg_q_r      <= 8'hFF;
            cand_r       <= 8'hFF;
            cnt_r        <= 8'd0;
            last_acc_r   <= 8'hFF;
            first_flag_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            seg_q_r      <= seg_in;
            cand_r       <= cand_next_s;
            cnt_r        <= cnt_next_s;
            last_acc_r   <= last_acc_next_s;
            first_flag_r <= first_next_s;
        end
    end

    // Output record holding register with valid/ready handshake; a blocked emit is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= 4'h0;
            out_dp    <= 1'b0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
        end else if (emit_s && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_value <= rec_s[3:0];
            out_dp    <= ~cand_next_s[7];
            out_blank <= rec_s[5];
            out_err   <= rec_s[4];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Sticky overrun flag; a new drop takes priority over the clear request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr <= 1'b0;
        end else if (emit_s && out_valid && !out_ready) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end else begin
            ovr <= ovr;
        end
    end

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed self-checking bench for seg7_decoder (STABLE_CYCLES = 4).
module tb_seg7_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_in;
    logic       out_ready;
    logic       ovr_clr;
    logic       out_valid;
    logic [3:0] out_value;
    logic       out_dp;
    logic       out_blank;
    logic       out_err;
    logic       ovr;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    seg7_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_dp    (out_dp),
        .out_blank (out_blank),
        .out_err   (out_err),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid is seen, bounded at 20.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n = n + 1;
        end
    endtask

    // Apply a pattern and check latency and the emitted record fields.
    task automatic emit_check(input string tag, input logic [7:0] pat, input logic [3:0] val,
                              input logic dp, input logic blank, input logic err);
        int n;
        seg_in = pat;
        wait_valid(n);
        check({tag, " latency"}, n, 5);
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " value"}, out_value, val);
        check({tag, " dp"}, out_dp, dp);
        check({tag, " blank"}, out_blank, blank);
        check({tag, " err"}, out_err, err);
    endtask

    logic [6:0] glyph [16];

    initial begin
        int nv;
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n     = 1'b0;
        seg_in    = 8'hFF;
        out_ready = 1'b1;
        ovr_clr   = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst valid", out_valid, 1'b0);
        check("rst value", out_value, 4'h0);
        check("rst dp", out_dp, 1'b0);
        check("rst blank", out_blank, 1'b0);
        check("rst err", out_err, 1'b0);
        check("rst ovr", ovr, 1'b0);

        // Basic decode: 0xA4 -> 2, dp not lit
        rst_n = 1'b1;
        emit_check("basic", 8'hA4, 4'h2, 1'b0, 1'b0, 1'b0);
        step();
        check("basic one-cycle", out_valid, 1'b0);
        nv = 0;
        repeat (6) begin
            step();
            if (out_valid) nv = nv + 1;
        end
        check("basic no repeat", nv, 0);

        // Sweep all glyphs with dp lit
        for (int i = 0; i < 16; i++) begin
            emit_check($sformatf("sweep%0d", i), {1'b0, glyph[i]}, 4'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        emit_check("blank", 8'hFF, 4'h0, 1'b0, 1'b1, 1'b0);
        step();
        emit_check("illegal", 8'hAA, 4'h0, 1'b0, 1'b0, 1'b1);
        step();

        // Glitch rejection
        emit_check("glitch base", 8'hF9, 4'h1, 1'b0, 1'b0, 1'b0);
        step();
        seg_in = 8'h80;
        repeat (3) step();
        seg_in = 8'hF9;
        nv = 0;
        repeat (20) begin
            step();
            if (out_valid) nv = nv + 1;
        end
        check("glitch no emit", nv, 0);

        // Backpressure and overrun
        out_ready = 1'b0;
        emit_check("bp first", 8'hC0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("bp ovr before", ovr, 1'b0);
        seg_in = 8'hB0;
        repeat (8) step();
        check("bp held valid", out_valid, 1'b1);
        check("bp held value", out_value, 4'h0);
        check("bp ovr set", ovr, 1'b1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("bp ovr clr", ovr, 1'b0);
        check("bp still valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        check("bp handshake", out_valid, 1'b0);
        nv = 0;
        repeat (6) begin
            step();
            if (out_valid) nv = nv + 1;
        end
        check("bp no replay", nv, 0);

        // Simultaneous accept and emit
        out_ready = 1'b0;
        emit_check("sim first", 8'hC0, 4'h0, 1'b0, 1'b0, 1'b0);
        seg_in = 8'h99;
        repeat (4) step();
        check("sim pre valid", out_valid, 1'b1);
        check("sim pre value", out_value, 4'h0);
        out_ready = 1'b1;
        step();
        check("sim valid kept", out_valid, 1'b1);
        check("sim new value", out_value, 4'h4);
        check("sim no ovr", ovr, 1'b0);
        step();
        check("sim drained", out_valid, 1'b0);

        // Reset mid-settle
        seg_in = 8'hA4;
        repeat (3) step();
        rst_n  = 1'b0;
        seg_in = 8'h99;
        step();
        check("midrst valid", out_valid, 1'b0);
        rst_n = 1'b1;
        emit_check("midrst", 8'h99, 4'h4, 1'b0, 1'b0, 1'b0);
        step();
        check("midrst drained", out_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255: consecutive stable samples required before a pattern is accepted.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port seg_in, input, 8 bits: active-low segment bus; bit0=a … bit6=g, bit7=dp; 0 = segment lit.
REQ-005 SHALL have port out_ready, input, 1 bit: consumer accepts the record when high with out_valid.
REQ-006 SHALL have port ovr_clr, input, 1 bit: clears the sticky overrun flag.
REQ-007 SHALL have port out_valid, output, 1 bit: a decoded record is presented.
REQ-008 SHALL have port out_value, output, 4 bits: decoded hex digit 0x0..0xF.
REQ-009 SHALL have port out_dp, output, 1 bit: decimal point lit (seg_in[7]==0).
REQ-010 SHALL have port out_blank, output, 1 bit: no segments a..g lit.
REQ-011 SHALL have port out_err, output, 1 bit: a..g pattern is not a legal glyph.
REQ-012 SHALL have port ovr, output, 1 bit: sticky flag; a record was dropped.

Function
REQ-013 SHALL register seg_in into seg_q every cycle; all decode and compare logic SHALL use seg_q only.
REQ-014 SHALL decode seg_q[6:0] as follows: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
REQ-015 SHALL report seg_q[6:0]==7F as out_blank=1, out_err=0, out_value=0.
REQ-016 SHALL report any other unlisted pattern as out_err=1, out_blank=0, out_value=0.
REQ-017 SHALL set out_dp = ~seg_q[7] independently of value, blank and err.
REQ-018 SHALL implement an FSM with states SETTLE and HOLD, and SHALL reset to SETTLE.
REQ-019 SETTLE: when seg_q differs from the candidate cand, the block SHALL load cand=seg_q and cnt=1; otherwise it SHALL increment cnt, saturating at STABLE_CYCLES.
REQ-020 SETTLE: on the edge where cnt reaches STABLE_CYCLES, the block SHALL emit the record for cand if cand≠last_acc or first_flag=1, SHALL set last_acc=cand and first_flag=0, and SHALL go to HOLD.
REQ-021 SETTLE: at that same edge, if cand==last_acc and first_flag=0, the block SHALL go to HOLD without emitting (glitch rejection, no duplicates).
REQ-022 HOLD: the block SHALL remain in HOLD while seg_q==last_acc; on any difference it SHALL go to SETTLE with cand=seg_q and cnt=1.
REQ-023 Latency: a pattern P applied to seg_in and held SHALL produce out_valid=1 exactly STABLE_CYCLES+1 rising edges after seg_in first presents P.
REQ-024 SHALL hold out_valid and all out_* fields constant while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid on an edge where out_valid=1 and out_ready=1, unless an emit occurs on that same edge.
REQ-026 Simultaneous accept and emit: the new record SHALL load and out_valid SHALL stay 1 (no bubble).
REQ-027 Emit while out_valid=1 and out_ready=0: the new record SHALL be dropped, ovr SHALL be set to 1, last_acc SHALL still update, and the held record SHALL be unchanged.
REQ-028 ovr SHALL clear on an edge with ovr_clr=1; if a set condition coincides with ovr_clr=1, set SHALL win.
REQ-029 A pattern change before cnt reaches STABLE_CYCLES SHALL restart counting from 1 with no emit.

Reset
REQ-030 On an edge with rst_n=0, the block SHALL force state=SETTLE, cnt=0, cand=FF, seg_q=FF, last_acc=FF, first_flag=1, out_valid=0, out_value=0, out_dp=0, out_blank=0, out_err=0, ovr=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending or held record with no output.
REQ-032 A pattern held across reset SHALL be re-emitted STABLE_CYCLES+1 edges after rst_n returns high.

Verification
REQ-033 Basic decode, STABLE_CYCLES=4, out_ready=1: hold seg_in=0xA4 → exactly 5 edges later out_valid=1 for one cycle, value=2, dp=0, blank=0, err=0.
REQ-034 Sweep: apply each of the 16 glyphs of REQ-014 with bit7=0 → values 0..F each emitted once with out_dp=1; then FF → out_blank=1; then 0xAA → out_err=1.
REQ-035 Glitch: hold 0xF9 until emitted, pulse 0x80 for 3 cycles, return to 0xF9 → no further out_valid.
REQ-036 Backpressure: out_ready=0; emit 0xC0, then emit 0xB0 → the record stays value=0 and ovr=1; pulse ovr_clr → ovr=0; raise out_ready → one handshake.
REQ-037 Simultaneous: out_valid=1 with out_ready=1 on the same edge as a new emit → out_valid stays 1 and the new value is presented next cycle.
REQ-038 Reset mid-settle: rst_n=0 at cnt=2 then released with seg_in held at 0x99 → out_valid=1 exactly 5 edges after release, value=4.
